sal_axi_cmd_port: RTL and testbench

- Slave-side command front-end of the SAL DDR controller.
- Accepts AXI AW/AR address beats and buffers them into downstream write/read command queues.
- Returns AXI B write responses from scheduler completion pulses.
- Exposes an APB register window for enable control and counters.

---
 rtl/sal_axi_cmd_pkg.sv | 33 +++
 rtl/sal_sync_fifo.sv | 51 +++++
 rtl/sal_axi_cmd_port.sv | 184 ++++++++++++++++++
 tb/tb_sal_axi_cmd_port.sv | 496 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sal_axi_cmd_pkg.sv
// Shared types, constants and register offsets for the SAL AXI command port.
// Legal command shape: 2-beat, 16-byte INCR bursts.
package sal_axi_cmd_pkg;

    localparam int AXI_ID_W   = 4;
    localparam int AXI_ADDR_W = 32;

    typedef logic [AXI_ID_W-1:0]   axi_id_t;
    typedef logic [AXI_ADDR_W-1:0] axi_addr_t;
    typedef logic [1:0]            axi_resp_t;

    localparam logic [2:0] AXI_SIZE_128   = 3'b100;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam axi_resp_t  RESP_OKAY      = 2'b00;
    localparam axi_resp_t  RESP_SLVERR    = 2'b10;

    localparam logic [11:0] REG_CTRL   = 12'h000;
    localparam logic [11:0] REG_STATUS = 12'h004;
    localparam logic [11:0] REG_AW_CNT = 12'h008;
    localparam logic [11:0] REG_AR_CNT = 12'h00C;
    localparam logic [11:0] REG_B_CNT  = 12'h010;

    function automatic logic cmd_err(
        input logic [7:0] len,
        input logic [2:0] size,
        input logic [1:0] burst
    );
        return !(len == 8'd1 &&
                 size == AXI_SIZE_128 &&
                 burst == AXI_BURST_INCR);
    endfunction

endpackage

// File: rtl/sal_sync_fifo.sv
// Synchronous FIFO with occupancy level; push ignored when full,
// pop ignored when empty. Depth must be a power of two (>= 2).
module sal_sync_fifo #(
    parameter int W = 8,
    parameter int D = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [$clog2(D):0] level
);

    localparam int AW = $clog2(D);

    logic [W-1:0] mem [D];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         do_push;
    logic         do_pop;

    assign level   = wptr - rptr;
    assign full    = level == (AW+1)'(D);
    assign empty   = level == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr[AW-1:0]] <= din;
    end

    // Reset input is active-high despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + 1'b1;
            if (do_pop)
                rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: rtl/sal_axi_cmd_port.sv
// AXI AW/AR/B command front-end with APB control window.
// Optional `SAL_PERF_CNT_EN adds AW/AR/B handshake counters.
module sal_axi_cmd_port
    import sal_axi_cmd_pkg::*;
#(
    parameter int ID_W       = 4,
    parameter int ADDR_W     = 32,
    parameter int CMDQ_DEPTH = 2,
    parameter int BQ_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [11:0]       paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ID_W-1:0]   awid,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ID_W-1:0]   arid,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    output logic              bvalid,
    input  logic              bready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              wcmd_valid,
    input  logic              wcmd_ready,
    output logic [ID_W-1:0]   wcmd_id,
    output logic [ADDR_W-1:0] wcmd_addr,
    output logic              wcmd_err,
    output logic              rcmd_valid,
    input  logic              rcmd_ready,
    output logic [ID_W-1:0]   rcmd_id,
    output logic [ADDR_W-1:0] rcmd_addr,
    output logic              rcmd_err,
    input  logic              wr_done,
    input  logic [ID_W-1:0]   wr_done_id,
    input  logic              wr_done_err,
    output logic              wr_done_ready
);

    localparam int CW = ID_W + ADDR_W + 1;
    localparam int BW = ID_W + 1;
    localparam int CL = $clog2(CMDQ_DEPTH) + 1;
    localparam int BL = $clog2(BQ_DEPTH) + 1;

    logic          en;
    logic          bovf;
    logic          aw_full, aw_empty, ar_full, ar_empty;
    logic          b_full, b_empty;
    logic [CL-1:0] aw_lvl, ar_lvl;
    logic [BL-1:0] b_lvl;
    logic [CW-1:0] aw_dout, ar_dout;
    logic [BW-1:0] b_dout;
    logic          aw_hs, ar_hs, b_hs;
    logic          b_push, b_drop;
    logic          b_err;
    logic [31:0]   aw_cnt, ar_cnt, b_cnt;
    logic [31:0]   status, rdata;
    logic          acc, wr, hit, ro;
    logic          unused_pwdata;

    assign awready = en && !aw_full && !rst_n;
    assign arready = en && !ar_full && !rst_n;
    assign aw_hs   = awvalid && awready;
    assign ar_hs   = arvalid && arready;

    sal_sync_fifo #(.W(CW), .D(CMDQ_DEPTH)) u_aw_q (
        .clk(clk), .rst_n(rst_n),
        .push(aw_hs),
        .din({cmd_err(awlen, awsize, awburst), awaddr, awid}),
        .pop(wcmd_valid && wcmd_ready),
        .dout(aw_dout), .full(aw_full),
        .empty(aw_empty), .level(aw_lvl)
    );

    sal_sync_fifo #(.W(CW), .D(CMDQ_DEPTH)) u_ar_q (
        .clk(clk), .rst_n(rst_n),
        .push(ar_hs),
        .din({cmd_err(arlen, arsize, arburst), araddr, arid}),
        .pop(rcmd_valid && rcmd_ready),
        .dout(ar_dout), .full(ar_full),
        .empty(ar_empty), .level(ar_lvl)
    );

    assign wcmd_valid = !aw_empty;
    assign {wcmd_err, wcmd_addr, wcmd_id} = aw_dout;
    assign rcmd_valid = !ar_empty;
    assign {rcmd_err, rcmd_addr, rcmd_id} = ar_dout;

    assign wr_done_ready = !b_full;
    assign b_push = wr_done && wr_done_ready;
    assign b_drop = wr_done && !wr_done_ready;
    assign b_hs   = bvalid && bready;

    sal_sync_fifo #(.W(BW), .D(BQ_DEPTH)) u_b_q (
        .clk(clk), .rst_n(rst_n),
        .push(b_push), .din({wr_done_err, wr_done_id}),
        .pop(b_hs),
        .dout(b_dout), .full(b_full),
        .empty(b_empty), .level(b_lvl)
    );

    assign bvalid       = !b_empty;
    assign {b_err, bid} = b_dout;
    assign bresp        = b_err ? RESP_SLVERR : RESP_OKAY;

    assign pready = 1'b1;
    assign acc    = psel && penable && !rst_n;
    assign wr     = acc && pwrite;
    assign unused_pwdata = ^{pwdata[31:17], pwdata[15:1]};

    always_comb begin
        status        = '0;
        status[1:0]   = 2'(aw_lvl);
        status[5:4]   = 2'(ar_lvl);
        status[10:8]  = 3'(b_lvl);
        status[16]    = bovf;
    end

    always_comb begin
        rdata = '0;
        hit   = 1'b1;
        ro    = 1'b1;
        unique case (paddr)
            REG_CTRL:   begin rdata = {31'b0, en}; ro = 1'b0; end
            REG_STATUS: begin rdata = status; ro = 1'b0; end
            REG_AW_CNT: rdata = aw_cnt;
            REG_AR_CNT: rdata = ar_cnt;
            REG_B_CNT:  rdata = b_cnt;
            default:    hit = 1'b0;
        endcase
    end

    assign prdata  = acc ? rdata : '0;
    assign pslverr = acc && (!hit || (pwrite && ro));

    // A drop in the same cycle as a clear keeps the overflow flag set.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            en   <= 1'b1;
            bovf <= 1'b0;
        end else begin
            if (wr && paddr == REG_CTRL)
                en <= pwdata[0];
            if (b_drop)
                bovf <= 1'b1;
            else if (wr && paddr == REG_STATUS && pwdata[16])
                bovf <= 1'b0;
        end
    end

`ifdef SAL_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            aw_cnt <= '0;
            ar_cnt <= '0;
            b_cnt  <= '0;
        end else begin
            if (aw_hs) aw_cnt <= aw_cnt + 32'd1;
            if (ar_hs) ar_cnt <= ar_cnt + 32'd1;
            if (b_hs)  b_cnt  <= b_cnt + 32'd1;
        end
    end
`else
    assign aw_cnt = '0;
    assign ar_cnt = '0;
    assign b_cnt  = '0;
`endif

endmodule

// File: tb/tb_sal_axi_cmd_port.sv
// Scoreboard bench for sal_axi_cmd_port.
module tb_sal_axi_cmd_port;
    import sal_axi_cmd_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        psel = 0, penable = 0, pwrite = 0;
    logic [11:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic        awvalid = 0, awready;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        arvalid = 0, arready;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        bvalid, bready = 0;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        wcmd_valid, wcmd_ready = 0;
    logic [3:0]  wcmd_id;
    logic [31:0] wcmd_addr;
    logic        wcmd_err;
    logic        rcmd_valid, rcmd_ready = 0;
    logic [3:0]  rcmd_id;
    logic [31:0] rcmd_addr;
    logic        rcmd_err;
    logic        wr_done = 0;
    logic [3:0]  wr_done_id = '0;
    logic        wr_done_err = 0;
    logic        wr_done_ready;

    always #5 clk = ~clk;

    sal_axi_cmd_port dut (
        .clk(clk), .rst_n(rst_n),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr),
        .awvalid(awvalid), .awready(awready), .awid(awid),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst),
        .arvalid(arvalid), .arready(arready), .arid(arid),
        .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .wcmd_valid(wcmd_valid), .wcmd_ready(wcmd_ready),
        .wcmd_id(wcmd_id), .wcmd_addr(wcmd_addr), .wcmd_err(wcmd_err),
        .rcmd_valid(rcmd_valid), .rcmd_ready(rcmd_ready),
        .rcmd_id(rcmd_id), .rcmd_addr(rcmd_addr), .rcmd_err(rcmd_err),
        .wr_done(wr_done), .wr_done_id(wr_done_id),
        .wr_done_err(wr_done_err), .wr_done_ready(wr_done_ready)
    );

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic        err;
    } cmd_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    cmd_t  wq[$];
    cmd_t  rq[$];
    bexp_t bq[$];

    int checks = 0;
    int errors = 0;
    int aw_sent = 0;
    int ar_sent = 0;
    int b_seen = 0;

    always @(negedge clk) begin : mon_w
        cmd_t e;
        if (!rst_n && wcmd_valid && wcmd_ready) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL wcmd_unexpected id=%0d addr=%h",
                         wcmd_id, wcmd_addr);
            end else begin
                e = wq.pop_front();
                if ({wcmd_id, wcmd_addr, wcmd_err} !==
                    {e.id, e.addr, e.err}) begin
                    errors++;
                    $display("FAIL wcmd got %0d/%h/%0d want %0d/%h/%0d",
                             wcmd_id, wcmd_addr, wcmd_err,
                             e.id, e.addr, e.err);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_r
        cmd_t e;
        if (!rst_n && rcmd_valid && rcmd_ready) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL rcmd_unexpected id=%0d addr=%h",
                         rcmd_id, rcmd_addr);
            end else begin
                e = rq.pop_front();
                if ({rcmd_id, rcmd_addr, rcmd_err} !==
                    {e.id, e.addr, e.err}) begin
                    errors++;
                    $display("FAIL rcmd got %0d/%h/%0d want %0d/%h/%0d",
                             rcmd_id, rcmd_addr, rcmd_err,
                             e.id, e.addr, e.err);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        bexp_t e;
        if (!rst_n && bvalid && bready) begin
            checks++;
            b_seen++;
            if (bq.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected bid=%0d bresp=%0d", bid, bresp);
            end else begin
                e = bq.pop_front();
                if ({bid, bresp} !== {e.id, e.resp}) begin
                    errors++;
                    $display("FAIL b got %0d/%0d want %0d/%0d",
                             bid, bresp, e.id, e.resp);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic apb_write(input logic [11:0] a,
                             input logic [31:0] d,
                             output logic err);
        psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
        @(posedge clk); #1 penable = 1;
        @(negedge clk); err = pslverr;
        @(posedge clk); #1 psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic apb_read(input logic [11:0] a,
                            output logic [31:0] d,
                            output logic err);
        psel = 1; penable = 0; pwrite = 0; paddr = a;
        @(posedge clk); #1 penable = 1;
        @(negedge clk); d = prdata; err = pslverr;
        @(posedge clk); #1 psel = 0; penable = 0;
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] a,
                           input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] bu, input logic exp_err);
        cmd_t c;
        bit ok = 0;
        awvalid = 1; awid = id; awaddr = a;
        awlen = len; awsize = sz; awburst = bu;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (awready) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL aw_accept id=%0d awready=0 want 1", id);
        end else begin
            c.id = id; c.addr = a; c.err = exp_err;
            wq.push_back(c);
            aw_sent++;
        end
        @(posedge clk); #1;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] a,
                           input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] bu, input logic exp_err);
        cmd_t c;
        bit ok = 0;
        arvalid = 1; arid = id; araddr = a;
        arlen = len; arsize = sz; arburst = bu;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (arready) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ar_accept id=%0d arready=0 want 1", id);
        end else begin
            c.id = id; c.addr = a; c.err = exp_err;
            rq.push_back(c);
            ar_sent++;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_a();
        awvalid = 0;
        arvalid = 0;
    endtask

    task automatic done_pulse(input logic [3:0] id, input logic err,
                              input logic exp_acc);
        bexp_t e;
        wr_done = 1; wr_done_id = id; wr_done_err = err;
        checks++;
        if (wr_done_ready !== exp_acc) begin
            errors++;
            $display("FAIL wr_done_ready got %0b want %0b",
                     wr_done_ready, exp_acc);
        end
        if (exp_acc) begin
            e.id = id;
            e.resp = err ? 2'b10 : 2'b00;
            bq.push_back(e);
        end
        @(posedge clk); #1 wr_done = 0;
    endtask

    task automatic wait_drain();
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wq.size() == 0 && rq.size() == 0 && bq.size() == 0) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain left w=%0d r=%0d b=%0d want 0",
                     wq.size(), rq.size(), bq.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_rd(input string nm, input logic [11:0] a,
                          input logic [31:0] exp_d, input logic exp_e);
        logic [31:0] d;
        logic e;
        apb_read(a, d, e);
        checks++;
        if (d !== exp_d || e !== exp_e) begin
            errors++;
            $display("FAIL %s got %h/%0b want %h/%0b",
                     nm, d, e, exp_d, exp_e);
        end
    endtask

    task automatic chk_wr(input string nm, input logic [11:0] a,
                          input logic [31:0] d, input logic exp_e);
        logic e;
        apb_write(a, d, e);
        checks++;
        if (e !== exp_e) begin
            errors++;
            $display("FAIL %s pslverr got %0b want %0b", nm, e, exp_e);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({awready, arready, wcmd_valid, rcmd_valid, bvalid}
            !== 5'b0 || prdata !== 32'h0 || pslverr !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs got %b%b%b%b%b prdata=%h want 0",
                     awready, arready, wcmd_valid, rcmd_valid,
                     bvalid, prdata);
        end
        @(posedge clk); #1 rst_n = 0;
        @(negedge clk);
        checks++;
        if ({awready, arready} !== 2'b11 || pready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready got %b%b%b want 111",
                     awready, arready, pready);
        end
        @(posedge clk); #1;
        chk_rd("rst_ctrl", REG_CTRL, 32'h1, 1'b0);
        chk_rd("rst_status", REG_STATUS, 32'h0, 1'b0);
        chk_rd("rst_awcnt", REG_AW_CNT, 32'h0, 1'b0);
    endtask

    task automatic test_aw_basic();
        wcmd_ready = 1;
        send_aw(4'd0, 32'h8, 8'd1, 3'd4, 2'd1, 1'b0);
        idle_a();
        @(negedge clk);
        checks++;
        if (wcmd_valid !== 1'b1 || wcmd_addr !== 32'h8 ||
            wcmd_err !== 1'b0) begin
            errors++;
            $display("FAIL aw_latency got v=%0b a=%h e=%0b want 1/8/0",
                     wcmd_valid, wcmd_addr, wcmd_err);
        end
        @(posedge clk); #1;
        wait_drain();
    endtask

    task automatic test_backpressure();
        wcmd_ready = 0;
        send_aw(4'd1, 32'h100, 8'd1, 3'd4, 2'd1, 1'b0);
        send_aw(4'd2, 32'h120, 8'd1, 3'd4, 2'd1, 1'b0);
        awid = 4'd3; awaddr = 32'h140;
        repeat (3) @(negedge clk);
        checks++;
        if (awready !== 1'b0) begin
            errors++;
            $display("FAIL aw_full_ready got %0b want 0", awready);
        end
        @(posedge clk); #1;
        chk_rd("status_aw2", REG_STATUS, 32'h2, 1'b0);
        wcmd_ready = 1;
        send_aw(4'd3, 32'h140, 8'd1, 3'd4, 2'd1, 1'b0);
        idle_a();
        wait_drain();
    endtask

    task automatic test_ar();
        rcmd_ready = 1;
        send_ar(4'd4, 32'h200, 8'd1, 3'd4, 2'd1, 1'b0);
        send_ar(4'd5, 32'h220, 8'd1, 3'd4, 2'd0, 1'b1);
        send_ar(4'd6, 32'h240, 8'd1, 3'd3, 2'd1, 1'b1);
        send_ar(4'd7, 32'h260, 8'd3, 3'd4, 2'd1, 1'b1);
        idle_a();
        wait_drain();
    endtask

    task automatic test_bresp();
        bready = 1;
        done_pulse(4'd0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (bvalid !== 1'b1 || bid !== 4'd0 || bresp !== 2'b00) begin
            errors++;
            $display("FAIL b_latency got v=%0b id=%0d r=%0d want 1/0/0",
                     bvalid, bid, bresp);
        end
        @(posedge clk); #1;
        done_pulse(4'd7, 1'b1, 1'b1);
        wait_drain();
    endtask

    task automatic test_err();
        wcmd_ready = 1;
        send_aw(4'd9, 32'h300, 8'd0, 3'd4, 2'd1, 1'b1);
        send_aw(4'd10, 32'h310, 8'd1, 3'd2, 2'd1, 1'b1);
        send_aw(4'd11, 32'h320, 8'd1, 3'd4, 2'd2, 1'b1);
        idle_a();
        wait_drain();
    endtask

    task automatic test_ctrl();
        wcmd_ready = 0;
        send_aw(4'd12, 32'h400, 8'd1, 3'd4, 2'd1, 1'b0);
        idle_a();
        chk_wr("ctrl_wr0", REG_CTRL, 32'h0, 1'b0);
        @(negedge clk);
        checks++;
        if ({awready, arready} !== 2'b00) begin
            errors++;
            $display("FAIL ctrl_dis_ready got %b%b want 00",
                     awready, arready);
        end
        @(posedge clk); #1;
        chk_rd("ctrl_rd0", REG_CTRL, 32'h0, 1'b0);
        wcmd_ready = 1;
        bready = 1;
        done_pulse(4'd3, 1'b0, 1'b1);
        wait_drain();
        chk_wr("ctrl_wr1", REG_CTRL, 32'h1, 1'b0);
        @(negedge clk);
        checks++;
        if ({awready, arready} !== 2'b11) begin
            errors++;
            $display("FAIL ctrl_en_ready got %b%b want 11",
                     awready, arready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_bovf();
        bready = 0;
        for (int i = 0; i < 4; i++)
            done_pulse(4'(i + 1), i[0], 1'b1);
        done_pulse(4'd8, 1'b0, 1'b0);
        chk_rd("status_bovf", REG_STATUS, 32'h0001_0400, 1'b0);
        chk_wr("status_clr", REG_STATUS, 32'h0001_0000, 1'b0);
        chk_rd("status_clr_rd", REG_STATUS, 32'h0000_0400, 1'b0);
        bready = 1;
        wait_drain();
        chk_rd("status_empty", REG_STATUS, 32'h0, 1'b0);
    endtask

    task automatic test_apb_err();
        chk_rd("rd_unmapped", 12'h020, 32'h0, 1'b1);
        chk_wr("wr_awcnt", REG_AW_CNT, 32'h5, 1'b1);
        chk_wr("wr_bcnt", REG_B_CNT, 32'h5, 1'b1);
        chk_wr("wr_unmapped", 12'h020, 32'h0, 1'b1);
        chk_wr("wr_unaligned", 12'h001, 32'h0, 1'b1);
        chk_rd("ctrl_kept", REG_CTRL, 32'h1, 1'b0);
    endtask

    task automatic test_reset_mid();
        wcmd_ready = 0;
        rcmd_ready = 0;
        bready = 0;
        send_aw(4'd13, 32'h500, 8'd1, 3'd4, 2'd1, 1'b0);
        send_ar(4'd14, 32'h600, 8'd1, 3'd4, 2'd1, 1'b0);
        idle_a();
        done_pulse(4'd2, 1'b0, 1'b1);
        rst_n = 1;
        #1;
        checks++;
        if ({wcmd_valid, rcmd_valid, bvalid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid got %b%b%b want 000",
                     wcmd_valid, rcmd_valid, bvalid);
        end
        wq.delete();
        rq.delete();
        bq.delete();
        aw_sent = 0;
        ar_sent = 0;
        b_seen = 0;
        @(posedge clk); #1 rst_n = 0;
        @(posedge clk); #1;
        chk_rd("reset_mid_status", REG_STATUS, 32'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_aw, exp_ar, exp_b;
        wcmd_ready = 1;
        rcmd_ready = 1;
        bready = 1;
        for (int i = 0; i < 6; i++)
            send_aw(4'(i), 32'h1000 + 32'(i) * 32'h20,
                    8'd1, 3'd4, 2'd1, 1'b0);
        idle_a();
        for (int i = 0; i < 5; i++)
            send_ar(4'(i + 8), 32'h2000 + 32'(i) * 32'h20,
                    8'd1, 3'd4, 2'd1, 1'b0);
        idle_a();
        for (int i = 0; i < 3; i++)
            done_pulse(4'(i), 1'b0, 1'b1);
        wait_drain();
`ifdef SAL_PERF_CNT_EN
        exp_aw = 32'(aw_sent);
        exp_ar = 32'(ar_sent);
        exp_b  = 32'(b_seen);
`else
        exp_aw = 32'h0;
        exp_ar = 32'h0;
        exp_b  = 32'h0;
`endif
        chk_rd("aw_cnt", REG_AW_CNT, exp_aw, 1'b0);
        chk_rd("ar_cnt", REG_AR_CNT, exp_ar, 1'b0);
        chk_rd("b_cnt", REG_B_CNT, exp_b, 1'b0);
    endtask

    initial begin
        test_reset();
        test_aw_basic();
        test_backpressure();
        test_ar();
        test_bresp();
        test_err();
        test_ctrl();
        test_bovf();
        test_apb_err();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
